// File: rtl/ha_sweep_checker_if.sv
// ha_sweep_checker_if
//
// Purpose: groups the signals between the sweep checker (initiator) and the
// half-adder responder it exercises.
//
// Signals:
//   a, b   : operands, driven by the checker
//   s      : responder sum
//   carry  : responder carry
//   done   : responder result-valid; only its rising edge is meaningful
//
// Modports:
//   master : checker side (drives a/b, observes s/carry/done)
//   slave  : responder side

interface ha_sweep_checker_if;
    logic a;
    logic b;
    logic s;
    logic carry;
    logic done;

    modport master (
        output a,
        output b,
        input  s,
        input  carry,
        input  done
    );

    modport slave (
        input  a,
        input  b,
        output s,
        output carry,
        output done
    );
endinterface

// File: rtl/ha_sweep_checker.sv
// ha_sweep_checker
//
// Purpose: on-chip self-test initiator for a half-adder responder. On start it
// walks the four operand pairs (0,0), (1,0), (0,1), (1,1) NUM_PASSES times,
// waits for a rising edge of done (or a timeout) after each pair and scores
// the returned sum/carry. Pass/error tallies saturate at 2^CNT_W-1.
//
// Parameters:
//   NUM_PASSES : full 4-vector sweeps per start (1..255)
//   TIMEOUT    : WAIT cycles allowed without a done rise (1..255)
//   CNT_W      : width of pass_cnt / err_cnt
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : 1-cycle sweep request, ignored while busy
//   ha          : half-adder link (master side: a/b out, s/carry/done in)
//   busy        : sweep in progress (cycle after start accept until END)
//   finished    : 1-cycle pulse in END
//   fail        : sticky, any mismatch or timeout since last start
//   timeout_err : sticky, any timeout since last start
//   pass_cnt    : vectors that matched
//   err_cnt     : vectors that mismatched or timed out
//
// Build option:
//   HA_CHK_STOP_ON_ERR_EN : when defined, the first failing vector ends the
//                           sweep and a/b keep that vector until next start.

module ha_sweep_checker #(
    parameter int unsigned NUM_PASSES = 1,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    ha_sweep_checker_if.master  ha,
    output logic                busy,
    output logic                finished,
    output logic                fail,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRIVE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_NEXT  = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    localparam logic [7:0]       TMO_LIM   = 8'(TIMEOUT);
    localparam logic [7:0]       LAST_PASS = 8'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef HA_CHK_STOP_ON_ERR_EN
    localparam logic STOP_ON_ERR = 1'b1;
`else
    localparam logic STOP_ON_ERR = 1'b0;
`endif

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       pass_q, pass_d;
    logic [7:0]       tcnt_q, tcnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             s_cap_q, s_cap_d;
    logic             c_cap_q, c_cap_d;
    logic             done_q;
    logic             fail_q, fail_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    logic rise;
    logic match;

    assign rise  = ha.done & ~done_q;
    // a_q/b_q still hold the vector under test while in CHECK.
    assign match = (s_cap_q == (a_q ^ b_q)) && (c_cap_q == (a_q & b_q));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        tcnt_d  = tcnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_cap_d = s_cap_q;
        c_cap_d = c_cap_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        pcnt_d  = pcnt_q;
        ecnt_d  = ecnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pcnt_d  = '0;
                    ecnt_d  = '0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    idx_d   = 2'd0;
                    pass_d  = 8'd0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                a_d     = idx_q[0];
                b_d     = idx_q[1];
                tcnt_d  = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A rise in the expiry cycle still gets scored normally.
                if (rise) begin
                    s_cap_d = ha.s;
                    c_cap_d = ha.carry;
                    state_d = ST_CHECK;
                end else if (tcnt_q == TMO_LIM) begin
                    if (ecnt_q != CNT_MAX) begin
                        ecnt_d = ecnt_q + 1'b1;
                    end
                    tmo_d   = 1'b1;
                    fail_d  = 1'b1;
                    state_d = STOP_ON_ERR ? ST_END : ST_NEXT;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (match) begin
                    if (pcnt_q != CNT_MAX) begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                    state_d = ST_NEXT;
                end else begin
                    if (ecnt_q != CNT_MAX) begin
                        ecnt_d = ecnt_q + 1'b1;
                    end
                    fail_d  = 1'b1;
                    state_d = STOP_ON_ERR ? ST_END : ST_NEXT;
                end
            end
            ST_NEXT: begin
                if ((idx_q == 2'd3) && (pass_q == LAST_PASS)) begin
                    state_d = ST_END;
                end else begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        pass_d = pass_q + 8'd1;
                    end
                    state_d = ST_DRIVE;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            pass_q  <= 8'd0;
            tcnt_q  <= 8'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            s_cap_q <= 1'b0;
            c_cap_q <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            pcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            tcnt_q  <= tcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_cap_q <= s_cap_d;
            c_cap_q <= c_cap_d;
            done_q  <= ha.done;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            pcnt_q  <= pcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    // Status decoded straight from the state register so reset clears it at once.
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_END);
    assign finished    = (state_q == ST_END);
    assign fail        = fail_q;
    assign timeout_err = tmo_q;
    assign pass_cnt    = pcnt_q;
    assign err_cnt     = ecnt_q;
    assign ha.a        = a_q;
    assign ha.b        = b_q;

endmodule

// File: tb/tb_ha_sweep_checker.sv
module tb_ha_sweep_checker;

    localparam int unsigned NP   = 2;
    localparam int unsigned TMO  = 5;
    localparam int          NVEC = 4 * NP;
`ifdef HA_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif
    localparam int M_PLAN = 0;
    localparam int M_TIE0 = 1;
    localparam int M_TIE1 = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, finished, fail, timeout_err;
    logic [7:0] pass_cnt, err_cnt;
    logic       busy2, finished2, fail2, tmo2;
    logic [1:0] pass2, err2;
    logic       rsp_s = 1'b0;
    logic       rsp_c = 1'b0;
    logic       rsp_done = 1'b0;

    ha_sweep_checker_if hif ();
    ha_sweep_checker_if hif2 ();

    // Both checkers run in lockstep, so one responder serves both.
    assign hif.s      = rsp_s;
    assign hif.carry  = rsp_c;
    assign hif.done   = rsp_done;
    assign hif2.s     = rsp_s;
    assign hif2.carry = rsp_c;
    assign hif2.done  = rsp_done;

    ha_sweep_checker #(.NUM_PASSES(NP), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ha          (hif),
        .busy        (busy),
        .finished    (finished),
        .fail        (fail),
        .timeout_err (timeout_err),
        .pass_cnt    (pass_cnt),
        .err_cnt     (err_cnt)
    );

    ha_sweep_checker #(.NUM_PASSES(NP), .TIMEOUT(TMO), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ha          (hif2),
        .busy        (busy2),
        .finished    (finished2),
        .fail        (fail2),
        .timeout_err (tmo2),
        .pass_cnt    (pass2),
        .err_cnt     (err2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Responder plan: per vector, done delay (cycles after a/b valid) and the s/carry returned.
    int mode = M_PLAN;
    int plan_d [NVEC];
    bit plan_s [NVEC];
    bit plan_c [NVEC];

    typedef struct {
        int mode;
        int dly;
        bit stuck;
        int restart;
        int e_pass;
        int e_err;
        int e_fail;
        int e_tmo;
        int e_fin;
        int e_a;
        int e_b;
    } scen_t;

    scen_t tbl [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int min3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Responder: a new vector is valid the cycle after busy rises, or whenever a/b change.
    bit         busy_prev = 1'b0;
    bit         first_pend = 1'b0;
    logic [1:0] ab_prev = 2'b00;
    int         cnt = -1;
    int         vec_i = 0;

    always @(negedge clk) begin
        bit launch;
        launch = 1'b0;
        if (!busy_prev && busy) begin
            first_pend = 1'b1;
            vec_i = -1;
            cnt = -1;
        end else if (first_pend) begin
            first_pend = 1'b0;
            launch = 1'b1;
        end else if (busy && ({hif.b, hif.a} != ab_prev)) begin
            launch = 1'b1;
        end
        if (launch) begin
            vec_i++;
            cnt = (vec_i < NVEC) ? plan_d[vec_i] : -1;
        end
        if (mode == M_TIE1) begin
            rsp_done = 1'b1;
        end else if (mode == M_TIE0) begin
            rsp_done = 1'b0;
        end else if (cnt == 0) begin
            rsp_done = 1'b1;
            rsp_s = plan_s[vec_i];
            rsp_c = plan_c[vec_i];
            cnt = -1;
        end else begin
            rsp_done = 1'b0;
            if (cnt > 0) cnt--;
        end
        busy_prev = busy;
        ab_prev = {hif.b, hif.a};
    end

    // Reference: score each planned vector from the half-adder truth and the timing rules.
    task automatic model(input int md, output int e_pass, output int e_err, output int e_fail,
                         output int e_tmo, output int e_fin, output int e_a, output int e_b);
        int len;
        e_pass = 0; e_err = 0; e_fail = 0; e_tmo = 0; e_a = 0; e_b = 0; len = 0;
        for (int i = 0; i < NVEC; i++) begin
            int va, vb;
            bit rise_ok, good;
            va = (i % 4) % 2;
            vb = (i % 4) / 2;
            e_a = va;
            e_b = vb;
            rise_ok = (md == M_PLAN) && (plan_d[i] <= int'(TMO));
            good = rise_ok && (int'(plan_s[i]) == (va ^ vb)) && (int'(plan_c[i]) == (va & vb));
            if (good) begin
                e_pass++;
                len += 4 + plan_d[i];
            end else begin
                e_err++;
                e_fail = 1;
                if (!rise_ok) begin
                    e_tmo = 1;
                    len += STOP ? 2 + int'(TMO) : 3 + int'(TMO);
                end else begin
                    len += STOP ? 3 + plan_d[i] : 4 + plan_d[i];
                end
                if (STOP) break;
            end
        end
        e_fin = 1 + len;
    endtask

    task automatic fill_plan(input int dly, input bit stuck);
        for (int i = 0; i < NVEC; i++) begin
            int va, vb;
            va = (i % 4) % 2;
            vb = (i % 4) / 2;
            plan_d[i] = dly;
            plan_s[i] = stuck ? 1'b0 : 1'(va ^ vb);
            plan_c[i] = 1'(va & vb);
        end
    endtask

    task automatic run_sweep(input string tag, input int restart_at, output int fin_k);
        fin_k = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                check({tag, " busy_rise"}, int'(busy), 1);
            end
            if (k == 2) check({tag, " first_ab"}, int'({hif.b, hif.a}), 0);
            if (restart_at > 0 && k == restart_at) start = 1'b1;
            if (restart_at > 0 && k == restart_at + 1) start = 1'b0;
            if (finished) begin
                fin_k = k;
                break;
            end
        end
        if (fin_k < 0) check({tag, " finish_wait"}, 0, 1);
    endtask

    task automatic compare(input string tag, input int fin_k, input int p, input int e,
                           input int f, input int t, input int fin, input int a, input int b);
        check({tag, " fin_cycle"}, fin_k, fin);
        check({tag, " pass_cnt"}, int'(pass_cnt), p);
        check({tag, " err_cnt"}, int'(err_cnt), e);
        check({tag, " fail"}, int'(fail), f);
        check({tag, " timeout_err"}, int'(timeout_err), t);
        check({tag, " ab"}, int'({hif.b, hif.a}), b * 2 + a);
        check({tag, " sat_pass"}, int'(pass2), min3(p));
        check({tag, " sat_err"}, int'(err2), min3(e));
        check({tag, " sat_fin"}, int'(finished2), 1);
        check({tag, " sat_ab"}, int'({hif2.b, hif2.a}), b * 2 + a);
        @(negedge clk);
        check({tag, " fin_pulse"}, int'(finished), 0);
        check({tag, " busy_end"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fin_k, p, e, f, t, fin, a, b;
        string tag;

        tbl[0] = '{M_PLAN, 2, 1'b0, 10, 8, 0, 0, 0, 49, 1, 1};
        tbl[4] = '{M_PLAN, 5, 1'b0, 0, 8, 0, 0, 0, 73, 1, 1};
        tbl[6] = '{M_PLAN, 0, 1'b0, 0, 8, 0, 0, 0, 33, 1, 1};
`ifdef HA_CHK_STOP_ON_ERR_EN
        tbl[1] = '{M_PLAN, 2, 1'b1, 0, 1, 1, 1, 0, 12, 1, 0};
        tbl[2] = '{M_TIE0, 2, 1'b0, 0, 0, 1, 1, 1, 8, 0, 0};
        tbl[3] = '{M_TIE1, 2, 1'b0, 0, 0, 1, 1, 1, 8, 0, 0};
        tbl[5] = '{M_PLAN, 6, 1'b0, 0, 0, 1, 1, 1, 8, 0, 0};
`else
        tbl[1] = '{M_PLAN, 2, 1'b1, 0, 4, 4, 1, 0, 49, 1, 1};
        tbl[2] = '{M_TIE0, 2, 1'b0, 0, 0, 8, 1, 1, 65, 1, 1};
        tbl[3] = '{M_TIE1, 2, 1'b0, 0, 0, 8, 1, 1, 65, 1, 1};
        tbl[5] = '{M_PLAN, 6, 1'b0, 0, 0, 8, 1, 1, 65, 1, 1};
`endif

        fill_plan(2, 1'b0);
        repeat (3) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst finished", int'(finished), 0);
        check("rst fail", int'(fail), 0);
        check("rst timeout_err", int'(timeout_err), 0);
        check("rst pass_cnt", int'(pass_cnt), 0);
        check("rst err_cnt", int'(err_cnt), 0);
        check("rst ab", int'({hif.b, hif.a}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            tag = $sformatf("tbl%0d", i);
            mode = tbl[i].mode;
            fill_plan(tbl[i].dly, tbl[i].stuck);
            repeat (3) @(negedge clk);
            run_sweep(tag, tbl[i].restart, fin_k);
            compare(tag, fin_k, tbl[i].e_pass, tbl[i].e_err, tbl[i].e_fail, tbl[i].e_tmo,
                    tbl[i].e_fin, tbl[i].e_a, tbl[i].e_b);
        end

        // Asynchronous reset while waiting on the second vector.
        mode = M_PLAN;
        fill_plan(2, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid busy", int'(busy), 1);
        check("mid pass_cnt", int'(pass_cnt), 1);
        check("mid a", int'(hif.a), 1);
        rst_n = 1'b0;
        #1;
        check("arst busy", int'(busy), 0);
        check("arst ab", int'({hif.b, hif.a}), 0);
        check("arst pass_cnt", int'(pass_cnt), 0);
        check("arst err_cnt", int'(err_cnt), 0);
        check("arst fail", int'(fail), 0);
        check("arst sat_pass", int'(pass2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model(M_PLAN, p, e, f, t, fin, a, b);
        run_sweep("post_rst", 0, fin_k);
        compare("post_rst", fin_k, p, e, f, t, fin, a, b);

        // Random delays (0..6 covers rise-at-expiry and late done) and random wrong results.
        for (int r = 0; r < 12; r++) begin
            tag = $sformatf("rnd%0d", r);
            mode = M_PLAN;
            for (int i = 0; i < NVEC; i++) begin
                int va, vb;
                va = (i % 4) % 2;
                vb = (i % 4) / 2;
                plan_d[i] = int'($urandom_range(0, 6));
                plan_s[i] = 1'(va ^ vb) ^ ($urandom_range(0, 4) == 0);
                plan_c[i] = 1'(va & vb) ^ ($urandom_range(0, 4) == 0);
            end
            model(M_PLAN, p, e, f, t, fin, a, b);
            repeat (3) @(negedge clk);
            run_sweep(tag, 0, fin_k);
            compare(tag, fin_k, p, e, f, t, fin, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
